// File: rtl/inst_fetch_q.sv
// inst_fetch_q: instruction fetch stage with a prefetch queue.
//
// Issues word-aligned fetches to a 1-cycle-latency instruction memory, pushes the
// returned {pc, inst} pairs into a FIFO and presents the head to decode through a
// valid/ready handshake. A branch redirect flushes the queue, kills any in-flight
// response and restarts fetch at the target. A halt opcode stops issue as soon as it
// is pushed; once decode pops it the stage goes sticky-halted and drops everything
// queued behind it.
//
// Ports
//   clk, rst        clock; asynchronous active-low reset
//   imem_en         fetch request this cycle
//   imem_addr       fetch byte address (current pc)
//   imem_rdata      instruction returned one cycle after imem_en
//   redirect_valid  restart fetch at redirect_pc (ignored once halted)
//   redirect_pc     redirect target; bits [1:0] are dropped
//   out_valid       queue head valid
//   out_ready       decode accepts the head
//   out_inst        head instruction (0 when empty)
//   out_pc          head pc (0 when empty)
//   fq_count        registered queue occupancy
//   halted          halt instruction delivered; sticky until reset
module inst_fetch_q #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INST_W   = 32,
    parameter int unsigned       FQ_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [5:0]        HALT_OPC = 6'b010001
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        imem_en,
    output logic [ADDR_W-1:0]           imem_addr,
    input  logic [INST_W-1:0]           imem_rdata,
    input  logic                        redirect_valid,
    input  logic [ADDR_W-1:0]           redirect_pc,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [INST_W-1:0]           out_inst,
    output logic [ADDR_W-1:0]           out_pc,
    output logic [$clog2(FQ_DEPTH):0]   fq_count,
    output logic                        halted
);

    localparam int unsigned PTR_W  = $clog2(FQ_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned OPC_HI = 31;
    localparam int unsigned OPC_LO = 26;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fq_entry_t;

    // Architectural state
    logic [ADDR_W-1:0] r_pc;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_infl_pc;
    logic              r_fetch_stop;
    logic              r_halted;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    fq_entry_t         r_q [FQ_DEPTH];

    // Combinational control
    fq_entry_t         w_head;
    logic              w_valid;
    logic              w_pop;
    logic              w_halt_pop;
    logic              w_redir;
    logic              w_flush;
    logic [CNT_W:0]    w_occ;
    logic              w_credit;
    logic              w_issue;
    logic              w_push;
    logic              w_push_halt;
    logic              w_unused_rpc_lsb;

    // Low address bits of the redirect target are architecturally ignored
    assign w_unused_rpc_lsb = ^redirect_pc[1:0];

    // Queue head and handshake
    always_comb begin
        w_head     = r_q[r_rd_ptr];
        w_valid    = (r_count != '0);
        w_pop      = w_valid && out_ready;
        w_halt_pop = w_pop && (w_head.inst[OPC_HI:OPC_LO] == HALT_OPC);
    end

    // A halt being popped beats a redirect in the same cycle; both empty the queue
    always_comb begin
        w_redir = redirect_valid && !r_halted && !w_halt_pop;
        w_flush = w_redir || w_halt_pop;
    end

    // Issue only if the queue has room for this response on top of the one in flight,
    // so a response push can never overflow. Request is held off while in reset.
    always_comb begin
        w_occ    = (CNT_W+1)'(r_count) + (CNT_W+1)'(r_inflight);
        w_credit = (w_occ < (CNT_W+1)'(FQ_DEPTH));
        w_issue  = rst && !r_halted && !r_fetch_stop && !redirect_valid && w_credit;
    end

    // Response lands one cycle after issue unless the queue is being flushed
    always_comb begin
        w_push      = r_inflight && !w_flush;
        w_push_halt = w_push && (imem_rdata[OPC_HI:OPC_LO] == HALT_OPC);
    end

    // Program counter and in-flight tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc       <= RESET_PC;
            r_inflight <= 1'b0;
            r_infl_pc  <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_redir) begin
                r_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
            end else if (w_issue) begin
                r_pc      <= r_pc + ADDR_W'(4);
                r_infl_pc <= r_pc;
            end
        end
    end

    // Fetch-stop (halt seen at push) and sticky halted (halt delivered)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_stop <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            if (w_redir) begin
                r_fetch_stop <= 1'b0;
            end else if (w_push_halt) begin
                r_fetch_stop <= 1'b1;
            end
            if (w_halt_pop) begin
                r_halted <= 1'b1;
            end
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else if (w_flush) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_count  <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_push);
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
        end
    end

    // Queue storage; contents are only observed through a valid head
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q[r_wr_ptr] <= {r_infl_pc, imem_rdata};
        end
    end

    // Outputs; head fields read as zero while the queue is empty
    always_comb begin
        imem_en   = w_issue;
        imem_addr = r_pc;
        out_valid = w_valid;
        out_inst  = w_valid ? w_head.inst : '0;
        out_pc    = w_valid ? w_head.pc   : '0;
        fq_count  = r_count;
        halted    = r_halted;
    end

endmodule

// File: tb/tb_inst_fetch_q.sv
// tb_inst_fetch_q: directed, table-driven bench for inst_fetch_q.
// Each table row sets the inputs for one cycle and lists the outputs expected in that
// cycle, before the next rising edge. A simple 64-word instruction memory answers
// fetches one cycle after imem_en; word i holds 0x100+i unless overridden.
module tb_inst_fetch_q;

    localparam logic [31:0] HALT_INST = 32'h4400_0000;

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic [2:0]  e_count;
        logic        e_en;
        logic [31:0] e_addr;
        logic        e_halted;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [2:0]  fq_count;
    logic        halted;

    logic [31:0] mem [64];
    vec_t        tbl [$];
    int          n_checks = 0;
    int          n_errors = 0;

    inst_fetch_q dut (
        .clk            (clk),
        .rst            (rst),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .fq_count       (fq_count),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    // One-cycle-latency instruction memory
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr[7:2]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_valid, input logic [31:0] e_pc,
                              input logic [31:0] e_inst, input logic [2:0] e_count,
                              input logic e_en, input logic [31:0] e_addr, input logic e_halted);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_valid));
        chk({tag, ".out_pc"},    out_pc,         e_pc);
        chk({tag, ".out_inst"},  out_inst,       e_inst);
        chk({tag, ".fq_count"},  32'(fq_count),  32'(e_count));
        chk({tag, ".imem_en"},   32'(imem_en),   32'(e_en));
        chk({tag, ".imem_addr"}, imem_addr,      e_addr);
        chk({tag, ".halted"},    32'(halted),    32'(e_halted));
    endtask

    task automatic add(input logic rv, input logic [31:0] rpc, input logic rdy,
                       input logic val, input logic [31:0] pc, input logic [31:0] inst,
                       input logic [2:0] cnt, input logic en, input logic [31:0] addr,
                       input logic hlt);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.e_valid = val; v.e_pc = pc;
        v.e_inst = inst; v.e_count = cnt; v.e_en = en; v.e_addr = addr; v.e_halted = hlt;
        tbl.push_back(v);
    endtask

    // Entered at posedge+1; leaves at posedge+1 after the last row's edge
    task automatic run_table(input string name);
        for (int i = 0; i < tbl.size(); i++) begin
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            out_ready      = tbl[i].rdy;
            #1;
            check_outs($sformatf("%s[%0d]", name, i), tbl[i].e_valid, tbl[i].e_pc,
                       tbl[i].e_inst, tbl[i].e_count, tbl[i].e_en, tbl[i].e_addr,
                       tbl[i].e_halted);
            @(posedge clk);
            #1;
        end
        redirect_valid = 1'b0;
        tbl.delete();
    endtask

    // Holds reset over two edges, checks reset outputs, releases at posedge+1
    task automatic do_reset(input string name);
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outs(name, 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 32'h0, 1'b0);
        rst = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h100 + 32'(i);

        // Streaming, back-pressure saturation and drain, then redirect with 3 queued
        do_reset("rst_a");
        add(0, 32'h0,  1, 0, 32'h00, 32'h000, 3'd0, 1, 32'h00, 0);
        add(0, 32'h0,  1, 0, 32'h00, 32'h000, 3'd0, 1, 32'h04, 0);
        add(0, 32'h0,  1, 1, 32'h00, 32'h100, 3'd1, 1, 32'h08, 0);
        add(0, 32'h0,  1, 1, 32'h04, 32'h101, 3'd1, 1, 32'h0C, 0);
        add(0, 32'h0,  0, 1, 32'h08, 32'h102, 3'd1, 1, 32'h10, 0);
        add(0, 32'h0,  0, 1, 32'h08, 32'h102, 3'd2, 1, 32'h14, 0);
        add(0, 32'h0,  0, 1, 32'h08, 32'h102, 3'd3, 0, 32'h18, 0);
        for (int k = 0; k < 7; k++)
            add(0, 32'h0, 0, 1, 32'h08, 32'h102, 3'd4, 0, 32'h18, 0);
        add(0, 32'h0,  1, 1, 32'h08, 32'h102, 3'd4, 0, 32'h18, 0);
        add(0, 32'h0,  1, 1, 32'h0C, 32'h103, 3'd3, 1, 32'h18, 0);
        add(0, 32'h0,  1, 1, 32'h10, 32'h104, 3'd2, 1, 32'h1C, 0);
        add(0, 32'h0,  1, 1, 32'h14, 32'h105, 3'd2, 1, 32'h20, 0);
        add(0, 32'h0,  0, 1, 32'h18, 32'h106, 3'd2, 1, 32'h24, 0);
        add(1, 32'h43, 0, 1, 32'h18, 32'h106, 3'd3, 0, 32'h28, 0);
        add(0, 32'h0,  1, 0, 32'h00, 32'h000, 3'd0, 1, 32'h40, 0);
        add(0, 32'h0,  1, 0, 32'h00, 32'h000, 3'd0, 1, 32'h44, 0);
        add(0, 32'h0,  1, 1, 32'h40, 32'h110, 3'd1, 1, 32'h48, 0);
        add(0, 32'h0,  1, 1, 32'h44, 32'h111, 3'd1, 1, 32'h4C, 0);
        run_table("stream");

        // Halt at word 3; redirect in the halt-pop cycle and after are ignored
        mem[3] = HALT_INST;
        do_reset("rst_b");
        add(0, 32'h0,  1, 0, 32'h00, 32'h000,   3'd0, 1, 32'h00, 0);
        add(0, 32'h0,  1, 0, 32'h00, 32'h000,   3'd0, 1, 32'h04, 0);
        add(0, 32'h0,  1, 1, 32'h00, 32'h100,   3'd1, 1, 32'h08, 0);
        add(0, 32'h0,  1, 1, 32'h04, 32'h101,   3'd1, 1, 32'h0C, 0);
        add(0, 32'h0,  1, 1, 32'h08, 32'h102,   3'd1, 1, 32'h10, 0);
        add(1, 32'h40, 1, 1, 32'h0C, HALT_INST, 3'd1, 0, 32'h14, 0);
        add(1, 32'h40, 1, 0, 32'h00, 32'h000,   3'd0, 0, 32'h14, 1);
        add(0, 32'h0,  1, 0, 32'h00, 32'h000,   3'd0, 0, 32'h14, 1);
        add(0, 32'h0,  1, 0, 32'h00, 32'h000,   3'd0, 0, 32'h14, 1);
        run_table("halt");
        mem[3] = 32'h103;

        // Halt fetched after a branch, redirected away before it is popped
        mem[17] = HALT_INST;
        do_reset("rst_c");
        add(1, 32'h40, 0, 0, 32'h00, 32'h000, 3'd0, 0, 32'h00, 0);
        add(0, 32'h0,  0, 0, 32'h00, 32'h000, 3'd0, 1, 32'h40, 0);
        add(0, 32'h0,  0, 0, 32'h00, 32'h000, 3'd0, 1, 32'h44, 0);
        add(0, 32'h0,  0, 1, 32'h40, 32'h110, 3'd1, 1, 32'h48, 0);
        add(1, 32'h80, 0, 1, 32'h40, 32'h110, 3'd2, 0, 32'h4C, 0);
        add(0, 32'h0,  1, 0, 32'h00, 32'h000, 3'd0, 1, 32'h80, 0);
        add(0, 32'h0,  1, 0, 32'h00, 32'h000, 3'd0, 1, 32'h84, 0);
        add(0, 32'h0,  1, 1, 32'h80, 32'h120, 3'd1, 1, 32'h88, 0);
        add(0, 32'h0,  1, 1, 32'h84, 32'h121, 3'd1, 1, 32'h8C, 0);
        run_table("halt_redir");
        mem[17] = 32'h111;

        // Fill the queue, then assert reset mid-cycle
        do_reset("rst_d");
        add(0, 32'h0, 0, 0, 32'h00, 32'h000, 3'd0, 1, 32'h00, 0);
        add(0, 32'h0, 0, 0, 32'h00, 32'h000, 3'd0, 1, 32'h04, 0);
        add(0, 32'h0, 0, 1, 32'h00, 32'h100, 3'd1, 1, 32'h08, 0);
        add(0, 32'h0, 0, 1, 32'h00, 32'h100, 3'd2, 1, 32'h0C, 0);
        add(0, 32'h0, 0, 1, 32'h00, 32'h100, 3'd3, 0, 32'h10, 0);
        add(0, 32'h0, 0, 1, 32'h00, 32'h100, 3'd4, 0, 32'h10, 0);
        run_table("fill");
        rst = 1'b0;
        #1;
        check_outs("async_rst", 1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 32'h0, 1'b0);

        // Restart from RESET_PC after release
        do_reset("rst_e");
        add(0, 32'h0, 1, 0, 32'h00, 32'h000, 3'd0, 1, 32'h00, 0);
        add(0, 32'h0, 1, 0, 32'h00, 32'h000, 3'd0, 1, 32'h04, 0);
        add(0, 32'h0, 1, 1, 32'h00, 32'h100, 3'd1, 1, 32'h08, 0);
        add(0, 32'h0, 1, 1, 32'h04, 32'h101, 3'd1, 1, 32'h0C, 0);
        run_table("restart");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
